// File: rtl/serial_subtractor_4.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A start/busy/done handshake frames each operation; results are held in
// diff/bout until the next operation completes.
// Optional feature: define SERIAL_SUB_OVF_EN to add the two's-complement
// overflow output ovf.
`timescale 1ns / 1ps

module serial_subtractor_4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            r_state;
    state_e            w_state_next;
    // r_a doubles as the partial-result register: each difference bit enters
    // from the MSB side as the consumed minuend bit leaves from the LSB side.
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_br;
    logic [CntW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_diff;
    logic              r_bout;
`ifdef SERIAL_SUB_OVF_EN
    logic              r_amsb;
    logic              r_bmsb;
    logic              r_ovf;
`endif

    logic              w_load;
    logic              w_last;
    logic              w_d;
    logic              w_br_next;

    // Full-subtractor cell on the current LSBs plus handshake decode.
    always_comb begin
        w_d       = r_a[0] ^ r_b[0] ^ r_br;
        w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
        w_load    = (r_state == StIdle) && start;
        w_last    = (r_state == StShift) && (r_cnt == CntW'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = StShift;
                end
            end
            StShift: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Operand capture, serial shifting and result load on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
            r_ovf  <= 1'b0;
`endif
        end else if (w_load) begin
            r_a    <= a;
            r_b    <= b;
            r_br   <= bin;
            r_cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_amsb <= a[WIDTH-1];
            r_bmsb <= b[WIDTH-1];
`endif
        end else if (r_state == StShift) begin
            r_a   <= {w_d, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_br  <= w_br_next;
            r_cnt <= r_cnt + CntW'(1);
            if (w_last) begin
                r_diff <= {w_d, r_a[WIDTH-1:1]};
                r_bout <= w_br_next;
`ifdef SERIAL_SUB_OVF_EN
                r_ovf  <= (r_amsb ^ r_bmsb) & (w_d ^ r_amsb);
`endif
            end
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule
